mem_wb_skid_stage: RTL and testbench
====================================

Name: mem_wb_skid_stage

Overview:
Parametrised MEM→WB pipeline register with a valid/ready handshake, flush, and an optional two-entry skid buffer.
- Carries the write-back result (data, register-write enable, destination address) to the register file.
- Exposes a forwarding lookup port on the output slot.
- Lets the back end stall without a combinational ready path through the stage.

Parameters:
DATA_W, 32, width of write-back data
ADDR_W, 5, width of destination register address
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single-entry stall register
ZERO_SUPPRESS, 1, 1 = a write to address 0 never asserts out_regwr or q_hit

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset, sampled on posedge clk
flush  input  1  discard all held entries
in_valid  input  1  upstream entry present
in_ready  output  1  stage can accept
in_data  input  DATA_W  write-back data
in_regwr  input  1  register-write enable
in_addr  input  ADDR_W  destination register
out_valid  output  1  output slot holds an entry
out_ready  input  1  write-back consumes output slot
out_data  output  DATA_W  held data
out_regwr  output  1  qualified write enable
out_addr  output  ADDR_W  held destination
q_addr  input  ADDR_W  forwarding query address
q_hit  output  1  output slot will write q_addr
q_data  output  DATA_W  data for forwarding (= out_data)

Behaviour:
- Storage: main slot (drives outputs) plus skid slot (present only when SKID=1). Each slot has a valid bit.
- Occupancy states: EMPTY (0 valid), ONE (main valid), FULL (main and skid valid).
- Handshake events: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready:
  - SKID=1: in_ready = ~skid_valid, a flop output with no combinational path from out_ready.
  - SKID=0: in_ready = ~main_valid | out_ready.
- Transitions on posedge clk, with reset and flush inactive:
  - EMPTY + accept → ONE; input loads main.
  - ONE + accept + drain → ONE; input loads main.
  - ONE + accept + ~drain → FULL; input loads skid (SKID=1 only).
  - ONE + ~accept + drain → EMPTY.
  - FULL + drain → ONE; skid moves to main, skid cleared. No accept is possible because in_ready=0.
  - FULL + ~drain → FULL; hold.
- Latency: an accepted entry appears on out_* at the next edge, provided the main slot is free or draining. Data is never reordered, duplicated or dropped except by flush.
- Flush (synchronous, checked after reset):
  - Both valid bits clear at the next edge.
  - A simultaneous accept counts as consumed and is discarded.
  - A simultaneous drain is still a valid transfer in that cycle.
  - Data registers may keep stale values; out_regwr must be 0 afterwards.
- out_regwr = main_valid & main_regwr & ~(ZERO_SUPPRESS & main_addr==0).
- q_hit = out_regwr & (main_addr == q_addr). Purely combinational. q_data = main_data.
- Reset (reset==0 at posedge clk):
  - Valid bits, data, regwr and addr all go to 0; reset overrides flush and handshakes.
  - After reset: out_valid=0, out_data=0, out_regwr=0, out_addr=0, q_hit=0, in_ready=1.
- Reset asserted mid-FULL: both entries are lost; no partial drain.
- Reset is not asynchronous: output values are unaffected until the first clock edge with reset low.

Decomposition:
- Shared package pipe_pkg:
  - default DATA_W/ADDR_W constants
  - packed wb_entry_t {data, regwr, addr}
- Natural sub-module: pipe_slot, one valid-gated register holding a wb_entry_t with load/clear. Instantiated twice (main, skid); the skid instance is generated only when SKID=1.

Test Plan:
1. Reset low two cycles, then high → out_valid=0, out_data=0, out_addr=0, out_regwr=0, in_ready=1 on the first edge with reset high.
2. Stream 4 entries (data 0x11..0x44, addr 1..4, regwr=1) with out_ready=1 → each appears one cycle after acceptance, in order, with out_regwr=1.
3. SKID=1: hold out_ready=0 and offer 3 entries → first two accepted (ONE then FULL), in_ready=0 on the third. Release out_ready → outputs 0x11 then 0x22, then the third entry is accepted.
4. FULL state, flush=1 together with in_valid → next cycle out_valid=0, in_ready=1, out_regwr=0; the flushed entries never appear.
5. Entry {data=0xDEAD, addr=0, regwr=1} with ZERO_SUPPRESS=1 → out_valid=1, out_regwr=0; q_addr=0 gives q_hit=0.
6. Entry {0xBEEF, addr=7, regwr=1} in main: q_addr=7 → q_hit=1, q_data=0xBEEF; q_addr=6 → q_hit=0. Assert reset with the entry held → next edge q_hit=0, out_data=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: default widths and the write-back entry shared by the MEM->WB stage
package pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  regwr;
    logic [ADDR_W_DEF-1:0] addr;
  } wb_entry_t;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid-gated entry register with load and clear
// Ports: clk, reset (sync, active-low), load (capture d, wins over clear),
//        clear (drop valid), d (entry in), valid/q (held entry)
module pipe_slot import pipe_pkg::*; #(
  parameter type T = wb_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  T     d,
  output logic valid,
  output T     q
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      valid <= load | (valid & ~clear);
      if (load) q <= d;
    end
  end
endmodule

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM->WB pipeline register with handshake, flush, optional skid entry
// Ports: clk, reset (sync, active-low), flush; in_valid/in_ready/in_data/in_regwr/in_addr
//        upstream; out_valid/out_ready/out_data/out_regwr/out_addr downstream;
//        q_addr/q_hit/q_data forwarding lookup on the output slot
module mem_wb_skid_stage import pipe_pkg::*; #(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter bit SKID          = 1'b1,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_regwr,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_regwr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit,
  output logic [DATA_W-1:0] q_data
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              regwr;
    logic [ADDR_W-1:0] addr;
  } entry_t;
  entry_t inEntry, mainQ, skidQ, mainD;
  logic mainValid, skidValid, accept, drain, mainLoad, mainClear;
  assign inEntry  = '{data: in_data, regwr: in_regwr, addr: in_addr};
  // with a skid entry, ready comes straight from a flop so out_ready never reaches in_ready
  assign in_ready = SKID ? ~skidValid : (~mainValid | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = mainValid & out_ready;
  // a held skid entry always has priority for the main slot; accept is impossible then
  assign mainD     = skidValid ? skidQ : inEntry;
  assign mainLoad  = ~flush & ((skidValid & drain) | (accept & (~mainValid | drain)));
  assign mainClear = flush | drain;
  pipe_slot #(.T(entry_t)) mainSlot (
    .clk(clk), .reset(reset), .load(mainLoad), .clear(mainClear),
    .d(mainD), .valid(mainValid), .q(mainQ)
  );
  if (SKID) begin : gSkid
    logic skidLoad, skidClear;
    assign skidLoad  = ~flush & accept & mainValid & ~drain;
    assign skidClear = flush | drain;
    pipe_slot #(.T(entry_t)) skidSlot (
      .clk(clk), .reset(reset), .load(skidLoad), .clear(skidClear),
      .d(inEntry), .valid(skidValid), .q(skidQ)
    );
  end else begin : gNoSkid
    assign skidValid = 1'b0;
    assign skidQ     = '0;
  end
  assign out_valid = mainValid;
  assign out_data  = mainQ.data;
  assign out_addr  = mainQ.addr;
  assign out_regwr = mainValid & mainQ.regwr & ~(ZERO_SUPPRESS & (mainQ.addr == '0));
  assign q_hit     = out_regwr & (mainQ.addr == q_addr);
  assign q_data    = mainQ.data;
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// tb_mem_wb_skid_stage: directed scoreboard bench for mem_wb_skid_stage (SKID=1, ZERO_SUPPRESS=1)
module tb_mem_wb_skid_stage;
  typedef struct packed {
    logic [31:0] data;
    logic        regwr;
    logic [4:0]  addr;
  } ent_t;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, in_ready, in_regwr = 1'b0;
  logic [31:0] in_data = '0, out_data, q_data;
  logic [4:0] in_addr = '0, out_addr, q_addr = '0;
  logic out_valid, out_ready = 1'b0, out_regwr, q_hit;
  int tests = 0, fails = 0;
  ent_t sb[$];
  always #5 clk = ~clk;
  mem_wb_skid_stage #(.DATA_W(32), .ADDR_W(5), .SKID(1'b1), .ZERO_SUPPRESS(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_regwr(in_regwr), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_regwr(out_regwr), .out_addr(out_addr),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic offer(input logic [31:0] d, input logic [4:0] a, input logic w);
    in_valid = 1'b1; in_data = d; in_addr = a; in_regwr = w;
  endtask
  // compare the output slot against the scoreboard head, then advance one clock
  task automatic cyc();
    logic acc, drn;
    ent_t e;
    chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      e = sb[0];
      chk("out_data", out_data, e.data);
      chk("out_addr", {27'd0, out_addr}, {27'd0, e.addr});
      chk("out_regwr", {31'd0, out_regwr}, {31'd0, e.regwr && e.addr != 5'd0});
    end
    acc = in_valid & in_ready;
    drn = out_valid & out_ready;
    e = '{data: in_data, regwr: in_regwr, addr: in_addr};
    @(posedge clk);
    if (drn && sb.size() != 0) void'(sb.pop_front());
    if (acc) sb.push_back(e);
    if (flush) sb.delete();
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_addr", {27'd0, out_addr}, 32'd0);
    chk("rst out_regwr", {31'd0, out_regwr}, 32'd0);
    chk("rst q_hit", {31'd0, q_hit}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(32'h11 * i, 5'(i), 1'b1);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    out_ready = 1'b0;
    offer(32'h11, 5'd1, 1'b1);
    chk("skid rdy0", {31'd0, in_ready}, 32'd1);
    cyc();
    offer(32'h22, 5'd2, 1'b1);
    chk("skid rdy1", {31'd0, in_ready}, 32'd1);
    cyc();
    offer(32'h33, 5'd3, 1'b1);
    chk("skid full rdy", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("skid hold rdy", {31'd0, in_ready}, 32'd0);
    chk("skid hold data", out_data, 32'h11);
    out_ready = 1'b1;
    cyc();
    chk("skid order", out_data, 32'h22);
    chk("skid rdy again", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    out_ready = 1'b0;
    offer(32'h55, 5'd5, 1'b1);
    cyc();
    offer(32'h66, 5'd6, 1'b1);
    cyc();
    offer(32'h77, 5'd7, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush out_regwr", {31'd0, out_regwr}, 32'd0);
    offer(32'h88, 5'd8, 1'b1);
    cyc();
    offer(32'h99, 5'd9, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("flush1 out_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    cyc();
    out_ready = 1'b0;
    offer(32'hDEAD, 5'd0, 1'b1);
    cyc();
    in_valid = 1'b0;
    q_addr = 5'd0;
    #1;
    chk("zero out_valid", {31'd0, out_valid}, 32'd1);
    chk("zero out_regwr", {31'd0, out_regwr}, 32'd0);
    chk("zero q_hit", {31'd0, q_hit}, 32'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    offer(32'hBEEF, 5'd7, 1'b1);
    cyc();
    in_valid = 1'b0;
    q_addr = 5'd7;
    #1;
    chk("fwd hit", {31'd0, q_hit}, 32'd1);
    chk("fwd data", q_data, 32'hBEEF);
    q_addr = 5'd6;
    #1;
    chk("fwd miss", {31'd0, q_hit}, 32'd0);
    q_addr = 5'd7;
    reset = 1'b0;
    #1;
    chk("sync rst hold", out_data, 32'hBEEF);
    @(posedge clk); #1;
    sb.delete();
    chk("rst q_hit", {31'd0, q_hit}, 32'd0);
    chk("rst data", out_data, 32'd0);
    chk("rst valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b1;
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
